// File: rtl/seq_bin_to_bcd_if.sv
// ---------------------------------------------------------------------------
// seq_bin_to_bcd_if
//
// Purpose : groups the request/result signals of the sequential
//           binary-to-BCD converter so that a requester and the converter
//           connect through one bundle.
//
// Parameters
//   BIN_WIDTH  width of the binary operand
//   DIGITS     number of BCD digits in the result
//
// Signals
//   start     requester -> converter  start a conversion (used while idle)
//   bin_in    requester -> converter  operand, taken together with start
//   blank_en  requester -> converter  leading-zero blanking, taken with start
//   busy      converter -> requester  conversion in progress
//   done      converter -> requester  one-cycle pulse, result registers updated
//   bcd_out   converter -> requester  packed digits, units digit in [3:0]
//   neg       converter -> requester  result was negative
//   overflow  converter -> requester  magnitude did not fit in DIGITS digits
//
// Modports
//   master  the requester side
//   slave   the converter side
// ---------------------------------------------------------------------------
interface seq_bin_to_bcd_if #(
   parameter int BIN_WIDTH = 16,
   parameter int DIGITS    = 5
);

   logic                   start;
   logic [BIN_WIDTH-1:0]   bin_in;
   logic                   blank_en;
   logic                   busy;
   logic                   done;
   logic [4*DIGITS-1:0]    bcd_out;
   logic                   neg;
   logic                   overflow;

   modport master (
      output start,
      output bin_in,
      output blank_en,
      input  busy,
      input  done,
      input  bcd_out,
      input  neg,
      input  overflow
   );

   modport slave (
      input  start,
      input  bin_in,
      input  blank_en,
      output busy,
      output done,
      output bcd_out,
      output neg,
      output overflow
   );

endinterface

// File: rtl/seq_bin_to_bcd.sv
// ---------------------------------------------------------------------------
// seq_bin_to_bcd
//
// Purpose : sequential binary-to-BCD converter using the shift-and-add-3
//           (double dabble) method, one operand bit per clock. It optionally
//           treats the operand as two's complement, and it can blank leading
//           zeros and place a minus code in front of the most significant
//           digit.
//
// Parameters
//   BIN_WIDTH    operand width (2..32)
//   DIGITS       BCD digits produced (1..10)
//   SIGNED_MODE  1 = operand is two's complement
//   BLANK_CODE   nibble emitted for a blanked digit
//   MINUS_CODE   nibble emitted for the minus sign
//
// Ports
//   clk   single clock, all state changes on the rising edge
//   rst   synchronous active-high reset
//   bus   seq_bin_to_bcd_if.slave: start/bin_in/blank_en in,
//         busy/done/bcd_out/neg/overflow out
//
// Timing : start is taken at edge N, done is high in the cycle after edge
//          N+BIN_WIDTH+1, and a new start is accepted in the done cycle.
// ---------------------------------------------------------------------------
module seq_bin_to_bcd #(
   parameter int         BIN_WIDTH   = 16,
   parameter int         DIGITS      = 5,
   parameter bit         SIGNED_MODE = 1'b0,
   parameter logic [3:0] BLANK_CODE  = 4'hF,
   parameter logic [3:0] MINUS_CODE  = 4'hA
) (
   input logic             clk,
   input logic             rst,
   seq_bin_to_bcd_if.slave bus
);

   // One spare digit above the visible ones so that a value too large for
   // DIGITS digits still shows up as a nonzero top digit.
   localparam int SCRATCH_W = 4 * (DIGITS + 1);
   localparam int CNT_W     = $clog2(BIN_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FORMAT
   } state_t;

   state_t                 state;
   state_t                 state_next;

   logic [BIN_WIDTH-1:0]   mag;
   logic [SCRATCH_W-1:0]   scratch;
   logic                   lost;
   logic                   sign_q;
   logic                   blank_q;
   logic [CNT_W-1:0]       count;

   logic [4*DIGITS-1:0]    bcd_q;
   logic                   neg_q;
   logic                   ovf_q;
   logic                   done_q;

   logic [BIN_WIDTH-1:0]   start_mag;
   logic                   start_sign;
   logic [SCRATCH_W-1:0]   adjusted;
   logic [4*DIGITS-1:0]    fmt_bcd;
   logic                   fmt_ovf;
   int                     msnz;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. SHIFT runs until the counter, loaded with BIN_WIDTH,
   // reaches its last iteration.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (count == CNT_W'(1)) begin
               state_next = FORMAT;
            end
         end
         FORMAT: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand magnitude and sign. Negating the most negative value wraps back
   // to 2^(BIN_WIDTH-1), which is exactly the right magnitude when the
   // register is read as unsigned.
   always_comb begin
      start_sign = (SIGNED_MODE != 1'b0) && bus.bin_in[BIN_WIDTH-1];
      start_mag  = bus.bin_in;
      if (start_sign) begin
         start_mag = ~bus.bin_in + BIN_WIDTH'(1);
      end
   end

   // Add-3 correction: any digit of 5 or more would exceed 9 after the next
   // doubling, so it is pre-biased so that the carry lands in the next digit.
   always_comb begin
      adjusted = scratch;
      for (int i = 0; i <= DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) begin
            adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
         end
      end
   end

   // Result formatting. msnz is the most significant nonzero visible digit
   // (0 when all are zero, so the units digit is never blanked). With
   // blanking, the position just above msnz carries the minus code for a
   // negative result when that position exists; everything higher is blank.
   // The sticky 'lost' bit keeps overflow correct even if the spare digit
   // itself is exceeded.
   always_comb begin
      fmt_ovf = lost || (scratch[SCRATCH_W-1 -: 4] != 4'd0);
      msnz    = 0;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] != 4'd0) begin
            msnz = i;
         end
      end
      fmt_bcd = scratch[4*DIGITS-1:0];
      if (blank_q) begin
         for (int i = 1; i < DIGITS; i++) begin
            if (i > msnz) begin
               if (sign_q && (i == msnz + 1)) begin
                  fmt_bcd[4*i +: 4] = MINUS_CODE;
               end else begin
                  fmt_bcd[4*i +: 4] = BLANK_CODE;
               end
            end
         end
      end
   end

   // Datapath. IDLE captures the request, SHIFT moves one operand bit into
   // the BCD scratch per clock, FORMAT publishes the result and pulses done.
   // Result registers only change in FORMAT or reset, so they hold between
   // conversions.
   always_ff @(posedge clk) begin
      if (rst) begin
         mag     <= '0;
         scratch <= '0;
         lost    <= 1'b0;
         sign_q  <= 1'b0;
         blank_q <= 1'b0;
         count   <= '0;
         bcd_q   <= '0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  mag     <= start_mag;
                  sign_q  <= start_sign;
                  blank_q <= bus.blank_en;
                  scratch <= '0;
                  lost    <= 1'b0;
                  count   <= CNT_W'(BIN_WIDTH);
               end
            end
            SHIFT: begin
               scratch <= {adjusted[SCRATCH_W-2:0], mag[BIN_WIDTH-1]};
               mag     <= {mag[BIN_WIDTH-2:0], 1'b0};
               lost    <= lost | adjusted[SCRATCH_W-1];
               count   <= count - CNT_W'(1);
            end
            FORMAT: begin
               bcd_q  <= fmt_bcd;
               neg_q  <= sign_q;
               ovf_q  <= fmt_ovf;
               done_q <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy     = (state != IDLE);
   assign bus.done     = done_q;
   assign bus.bcd_out  = bcd_q;
   assign bus.neg      = neg_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// ---------------------------------------------------------------------------
// tb_seq_bin_to_bcd
//
// Three converter instances share clock and reset:
//   dut 0  BIN_WIDTH=16 DIGITS=5 unsigned
//   dut 1  BIN_WIDTH=16 DIGITS=5 signed
//   dut 2  BIN_WIDTH=16 DIGITS=4 unsigned
// Expected results are queued when a start is driven and popped whenever a
// done pulse appears, which also checks the start-to-done latency.
// ---------------------------------------------------------------------------
module tb_seq_bin_to_bcd;

   localparam int W   = 16;
   localparam int LAT = W + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   seq_bin_to_bcd_if #(.BIN_WIDTH(W), .DIGITS(5)) bus_uns ();
   seq_bin_to_bcd_if #(.BIN_WIDTH(W), .DIGITS(5)) bus_sgn ();
   seq_bin_to_bcd_if #(.BIN_WIDTH(W), .DIGITS(4)) bus_d4 ();

   seq_bin_to_bcd #(.BIN_WIDTH(W), .DIGITS(5), .SIGNED_MODE(1'b0)) u_uns (
      .clk (clk),
      .rst (rst),
      .bus (bus_uns)
   );

   seq_bin_to_bcd #(.BIN_WIDTH(W), .DIGITS(5), .SIGNED_MODE(1'b1)) u_sgn (
      .clk (clk),
      .rst (rst),
      .bus (bus_sgn)
   );

   seq_bin_to_bcd #(.BIN_WIDTH(W), .DIGITS(4), .SIGNED_MODE(1'b0)) u_d4 (
      .clk (clk),
      .rst (rst),
      .bus (bus_d4)
   );

   typedef struct {
      int          sel;
      logic [15:0] bin;
      logic        blank;
      logic [19:0] bcd;
      logic        neg;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [19:0] bcd;
      logic        neg;
      logic        ovf;
      int          due;
   } exp_t;

   exp_t q_uns[$];
   exp_t q_sgn[$];
   exp_t q_d4[$];

   int       errors = 0;
   int       checks = 0;
   int       cycle  = 0;
   logic [2:0] done_seen = 3'b000;

   // Result accessors per instance (the 4-digit one is zero-extended).
   function automatic logic get_done(input int sel);
      case (sel)
         0:       return bus_uns.done;
         1:       return bus_sgn.done;
         default: return bus_d4.done;
      endcase
   endfunction

   function automatic logic get_busy(input int sel);
      case (sel)
         0:       return bus_uns.busy;
         1:       return bus_sgn.busy;
         default: return bus_d4.busy;
      endcase
   endfunction

   function automatic logic [19:0] get_bcd(input int sel);
      case (sel)
         0:       return bus_uns.bcd_out;
         1:       return bus_sgn.bcd_out;
         default: return {4'h0, bus_d4.bcd_out};
      endcase
   endfunction

   function automatic logic get_neg(input int sel);
      case (sel)
         0:       return bus_uns.neg;
         1:       return bus_sgn.neg;
         default: return bus_d4.neg;
      endcase
   endfunction

   function automatic logic get_ovf(input int sel);
      case (sel)
         0:       return bus_uns.overflow;
         1:       return bus_sgn.overflow;
         default: return bus_d4.overflow;
      endcase
   endfunction

   // Reference for 5-digit unsigned results, computed by repeated division.
   function automatic logic [19:0] model_uns(input int unsigned value, input logic blank);
      logic [3:0]  d [5];
      int unsigned v;
      int          top;
      logic [19:0] r;
      v   = value;
      top = 0;
      for (int i = 0; i < 5; i++) begin
         d[i] = 4'(v % 10);
         v    = v / 10;
      end
      for (int i = 0; i < 5; i++) begin
         if (d[i] != 4'd0) top = i;
      end
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = (blank && (i > top)) ? 4'hF : d[i];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
      end
   endtask

   task automatic drive(input int sel, input logic s, input logic [15:0] b, input logic bl);
      case (sel)
         0: begin
            bus_uns.start = s; bus_uns.bin_in = b; bus_uns.blank_en = bl;
         end
         1: begin
            bus_sgn.start = s; bus_sgn.bin_in = b; bus_sgn.blank_en = bl;
         end
         default: begin
            bus_d4.start = s; bus_d4.bin_in = b; bus_d4.blank_en = bl;
         end
      endcase
   endtask

   task automatic push_exp(input int sel, input exp_t e);
      case (sel)
         0:       q_uns.push_back(e);
         1:       q_sgn.push_back(e);
         default: q_d4.push_back(e);
      endcase
   endtask

   // Pop the oldest expectation for this instance and compare the result.
   task automatic checkOutput(input int sel);
      exp_t  e;
      logic  have;
      string tag;
      have = 1'b0;
      case (sel)
         0: if (q_uns.size() > 0) begin e = q_uns.pop_front(); have = 1'b1; end
         1: if (q_sgn.size() > 0) begin e = q_sgn.pop_front(); have = 1'b1; end
         default: if (q_d4.size() > 0) begin e = q_d4.pop_front(); have = 1'b1; end
      endcase
      tag = $sformatf("dut%0d@%0d", sel, cycle);
      if (!have) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s unexpected_done: got done=1, required no done", tag);
         return;
      end
      check({tag, " bcd"},      32'(get_bcd(sel)),  32'(e.bcd));
      check({tag, " neg"},      32'(get_neg(sel)),  32'(e.neg));
      check({tag, " overflow"}, 32'(get_ovf(sel)),  32'(e.ovf));
      check({tag, " latency"},  32'(cycle),         32'(e.due));
      check({tag, " busy"},     32'(get_busy(sel)), 32'd0);
   endtask

   // Advance to the next falling edge and score any done pulses.
   task automatic tick();
      @(negedge clk);
      cycle++;
      for (int s = 0; s < 3; s++) begin
         if (get_done(s)) begin
            done_seen[s] = 1'b1;
            checkOutput(s);
         end
      end
   endtask

   // Start a conversion (one-cycle start pulse) and queue its expectation.
   task automatic applyStimulus(input int sel, input logic [15:0] bin, input logic blank,
                                input logic [19:0] bcd, input logic neg, input logic ovf);
      exp_t e;
      e.bcd = bcd;
      e.neg = neg;
      e.ovf = ovf;
      e.due = cycle + LAT;
      drive(sel, 1'b1, bin, blank);
      push_exp(sel, e);
      tick();
      drive(sel, 1'b0, bin, blank);
   endtask

   task automatic waitDone(input int sel, input int budget);
      done_seen[sel] = 1'b0;
      for (int k = 0; k < budget && !done_seen[sel]; k++) begin
         tick();
      end
      if (!done_seen[sel]) begin
         checks++;
         errors++;
         $display("[TB] FAIL dut%0d done_timeout: got no done in %0d cycles, required done", sel, budget);
      end
   endtask

   task automatic checkResetState(input string name, input int sel);
      check({name, " busy"},     32'(get_busy(sel)), 32'd0);
      check({name, " done"},     32'(get_done(sel)), 32'd0);
      check({name, " bcd"},      32'(get_bcd(sel)),  32'd0);
      check({name, " neg"},      32'(get_neg(sel)),  32'd0);
      check({name, " overflow"}, 32'(get_ovf(sel)),  32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      logic [15:0] rb;
      logic        rbl;

      for (int s = 0; s < 3; s++) drive(s, 1'b0, 16'h0000, 1'b0);

      // sel, bin, blank, bcd (d4..d0), neg, overflow
      vecs.push_back('{0, 16'd0,     1'b1, 20'hFFFF0, 1'b0, 1'b0});
      vecs.push_back('{0, 16'd65535, 1'b0, 20'h65535, 1'b0, 1'b0});
      vecs.push_back('{0, 16'd65535, 1'b1, 20'h65535, 1'b0, 1'b0});
      vecs.push_back('{0, 16'd42,    1'b1, 20'hFFF42, 1'b0, 1'b0});
      vecs.push_back('{0, 16'd42,    1'b0, 20'h00042, 1'b0, 1'b0});
      vecs.push_back('{0, 16'd1000,  1'b1, 20'hF1000, 1'b0, 1'b0});
      vecs.push_back('{1, 16'hFF85,  1'b1, 20'hFA123, 1'b1, 1'b0});
      vecs.push_back('{1, 16'h8000,  1'b1, 20'h32768, 1'b1, 1'b0});
      vecs.push_back('{1, 16'hFF85,  1'b0, 20'h00123, 1'b1, 1'b0});
      vecs.push_back('{1, 16'hFFFF,  1'b1, 20'hFFFA1, 1'b1, 1'b0});
      vecs.push_back('{1, 16'h007B,  1'b1, 20'hFF123, 1'b0, 1'b0});
      vecs.push_back('{1, 16'h7FFF,  1'b1, 20'h32767, 1'b0, 1'b0});
      vecs.push_back('{1, 16'h0000,  1'b1, 20'hFFFF0, 1'b0, 1'b0});
      vecs.push_back('{1, 16'hD8F1,  1'b1, 20'hA9999, 1'b1, 1'b0});
      vecs.push_back('{2, 16'd12345, 1'b1, 20'h02345, 1'b0, 1'b1});
      vecs.push_back('{2, 16'd9999,  1'b0, 20'h09999, 1'b0, 1'b0});
      vecs.push_back('{2, 16'd10000, 1'b1, 20'h0FFF0, 1'b0, 1'b1});
      vecs.push_back('{2, 16'd7,     1'b1, 20'h0FFF7, 1'b0, 1'b0});
      vecs.push_back('{2, 16'd0,     1'b0, 20'h00000, 1'b0, 1'b0});

      // Reset state of every instance.
      rst = 1'b1;
      tick();
      tick();
      for (int s = 0; s < 3; s++) checkResetState($sformatf("reset dut%0d", s), s);
      rst = 1'b0;
      tick();

      // Table-driven vectors.
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].sel, vecs[i].bin, vecs[i].blank, vecs[i].bcd, vecs[i].neg, vecs[i].ovf);
         waitDone(vecs[i].sel, LAT + 5);
      end

      // Random unsigned operands against the division model.
      for (int i = 0; i < 8; i++) begin
         rb  = 16'($urandom);
         rbl = 1'($urandom);
         applyStimulus(0, rb, rbl, model_uns(32'(rb), rbl), 1'b0, 1'b0);
         waitDone(0, LAT + 5);
      end

      // Back-to-back: the second start is driven in the done cycle, so its
      // result must arrive exactly LAT cycles later.
      applyStimulus(0, 16'd65535, 1'b0, 20'h65535, 1'b0, 1'b0);
      waitDone(0, LAT + 5);
      applyStimulus(0, 16'd12, 1'b1, 20'hFFF12, 1'b0, 1'b0);
      waitDone(0, LAT + 5);

      // start held high with a changing operand: only the first value counts.
      begin
         exp_t e;
         e.bcd = 20'hFF100;
         e.neg = 1'b0;
         e.ovf = 1'b0;
         e.due = cycle + LAT;
         drive(0, 1'b1, 16'd100, 1'b1);
         push_exp(0, e);
         for (int k = 0; k < LAT - 1; k++) begin
            tick();
            drive(0, 1'b1, 16'($urandom), 1'b0);
         end
         waitDone(0, 3);
         drive(0, 1'b0, 16'd0, 1'b0);
         for (int k = 0; k < LAT + 6; k++) tick();
         check("held_start idle busy", 32'(get_busy(0)), 32'd0);
      end

      // Reset five cycles into a conversion aborts it without a done pulse.
      drive(0, 1'b1, 16'd999, 1'b0);
      tick();
      drive(0, 1'b0, 16'd999, 1'b0);
      for (int k = 0; k < 4; k++) tick();
      check("abort busy before reset", 32'(get_busy(0)), 32'd1);
      rst = 1'b1;
      tick();
      checkResetState("abort", 0);
      // Reset wins over a simultaneous start.
      drive(0, 1'b1, 16'd555, 1'b0);
      tick();
      check("rst_over_start busy", 32'(get_busy(0)), 32'd0);
      drive(0, 1'b0, 16'd0, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < LAT + 6; k++) tick();
      check("abort no restart busy", 32'(get_busy(0)), 32'd0);

      // Fresh conversion after the abort, then the result must hold.
      applyStimulus(0, 16'd4321, 1'b1, 20'hF4321, 1'b0, 1'b0);
      waitDone(0, LAT + 5);
      for (int k = 0; k < 3; k++) tick();
      check("hold bcd", 32'(get_bcd(0)), 32'h000F4321);
      check("hold done", 32'(get_done(0)), 32'd0);

      // Nothing may remain outstanding.
      check("pending dut0", 32'(q_uns.size()), 32'd0);
      check("pending dut1", 32'(q_sgn.size()), 32'd0);
      check("pending dut2", 32'(q_d4.size()),  32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no completion, required end of test");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/seq_bin_to_bcd.md
SEQ_BIN_TO_BCD -- requirements
Module: seq_bin_to_bcd

Interface
REQ-001 SHALL have parameter BIN_WIDTH, default 16, binary input width (2..32).
REQ-002 SHALL have parameter DIGITS, default 5, BCD output digit count (1..10).
REQ-003 SHALL have parameter SIGNED_MODE, default 0; 1 = bin_in is two's complement.
REQ-004 SHALL have parameter BLANK_CODE, default 4'hF, nibble emitted for a blanked digit.
REQ-005 SHALL have parameter MINUS_CODE, default 4'hA, nibble emitted for a minus sign.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  request conversion; sampled only when busy=0.
REQ-009 bin_in  in  BIN_WIDTH  value to convert; sampled with start.
REQ-010 blank_en  in  1  leading-zero blanking enable; sampled with start.
REQ-011 busy  out  1  conversion in progress.
REQ-012 done  out  1  one-cycle pulse, results valid and updated.
REQ-013 bcd_out  out  4*DIGITS  packed digits, digit 0 (units) in bits [3:0].
REQ-014 neg  out  1  result was negative (always 0 when SIGNED_MODE=0).
REQ-015 overflow  out  1  magnitude exceeds 10^DIGITS-1.

Function
REQ-016 SHALL implement states IDLE, SHIFT, FORMAT.
REQ-017 IDLE: on edge with start=1, SHALL latch magnitude (two's-complement negate if SIGNED_MODE=1 and MSB=1), sign, blank_en, clear BCD scratch, load iteration counter BIN_WIDTH, go SHIFT, busy=1.
REQ-018 Magnitude register SHALL be BIN_WIDTH bits unsigned; -2^(BIN_WIDTH-1) SHALL convert to magnitude 2^(BIN_WIDTH-1) without error.
REQ-019 SHIFT: each edge SHALL add 3 to every scratch digit >=5, then shift {scratch,magnitude} left one bit; exactly BIN_WIDTH iterations, then go FORMAT.
REQ-020 Scratch SHALL be DIGITS+1 digits wide so an overflowing digit is captured, not lost.
REQ-021 FORMAT: one edge SHALL register bcd_out, neg, overflow, assert done, deassert busy, go IDLE.
REQ-022 overflow SHALL be 1 iff scratch digit DIGITS is nonzero; bcd_out then holds the low DIGITS digits, blanking still applied.
REQ-023 With blank_en=1, every digit above the most significant nonzero digit SHALL be BLANK_CODE; digit 0 SHALL never be blanked.
REQ-024 With blank_en=1 and neg=1, the digit immediately above the most significant nonzero digit SHALL be MINUS_CODE if that position exists (< DIGITS), else sign is reported on neg only.
REQ-025 With blank_en=0, all digits SHALL be numeric, no minus code.
REQ-026 Latency: start sampled at edge N -> done high in the cycle after edge N+BIN_WIDTH+1; throughput one conversion per BIN_WIDTH+2 cycles.
REQ-027 done SHALL be high exactly one cycle; busy=0 in that cycle and start SHALL be accepted at the following edge.
REQ-028 start while busy=1 SHALL be ignored with no effect on the running conversion.
REQ-029 bcd_out, neg, overflow SHALL hold their values until the next FORMAT edge or rst.

Reset
REQ-030 rst=1 at any edge SHALL force IDLE, busy=0, done=0, bcd_out=0, neg=0, overflow=0, aborting any conversion with no done pulse.
REQ-031 rst SHALL take priority over start in the same cycle.

Verification (BIN_WIDTH=16, DIGITS=5 unless stated; digits listed d4..d0)
REQ-032 Unsigned, bin_in=0, blank_en=1, start at edge N -> done after edge N+17, bcd_out F F F F 0, neg=0, overflow=0.
REQ-033 Unsigned, bin_in=65535, blank_en=0 -> 6 5 5 3 5, overflow=0; back-to-back start in done cycle -> second done exactly 18 cycles later.
REQ-034 SIGNED_MODE=1, bin_in=16'hFF85 (-123), blank_en=1 -> F A 1 2 3, neg=1; bin_in=16'h8000 -> 3 2 7 6 8, neg=1, no MINUS_CODE.
REQ-035 DIGITS=4, unsigned, bin_in=12345, blank_en=1 -> 2 3 4 5, overflow=1.
REQ-036 start=1 held through conversion with changing bin_in -> one result for the value sampled at first start, no restart.
REQ-037 rst asserted 5 cycles into a conversion -> next cycle busy=0, outputs zero, no done pulse; fresh start then converts normally.
